// File: rtl/loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_e;

   localparam int unsigned BYTES_PER_WORD = 4;

   // Bit offset of byte lane idx inside a word, lane 0 being the least significant.
   function automatic int unsigned lane_lsb(input logic [1:0] idx, input int unsigned lane_w);
      return 32'(idx) * lane_w;
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// one little-endian byte per cycle, starting at BASE_ADDR.
module imem_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned WORD_WIDTH    = 32,
   parameter int unsigned MEM_BYTES     = 4096,
   parameter int unsigned BASE_ADDR     = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [WORD_WIDTH-1:0]    word_in,
   input  logic                     word_valid,
   input  logic                     word_last,
   output logic                     word_ready,
   output logic                     wr_en,
   output logic [ADDRESS_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [ADDRESS_WIDTH-1:0] word_count
);

   localparam logic [ADDRESS_WIDTH-1:0] BASE    = ADDRESS_WIDTH'(BASE_ADDR);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_OK = ADDRESS_WIDTH'(MEM_BYTES - BYTES_PER_WORD);

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [ADDRESS_WIDTH-1:0] count_q, count_d;
   logic [WORD_WIDTH-1:0]    word_q, word_d;
   logic                     last_q, last_d;
   logic [1:0]               idx_q, idx_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= BASE;
         count_q <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         word_q  <= word_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      word_d  = word_q;
      last_d  = last_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_ACCEPT;
               addr_d  = BASE;
               count_d = '0;
            end
         end
         S_ACCEPT: begin
            // Overflow is decided before any byte lands, so a word is all-or-nothing.
            if (word_valid) begin
               if (addr_q <= LAST_OK) begin
                  word_d  = word_in;
                  last_d  = word_last;
                  idx_d   = 2'd0;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_ERROR;
               end
            end
         end
         S_WRITE: begin
            addr_d = addr_q + ADDRESS_WIDTH'(1);
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               count_d = count_q + ADDRESS_WIDTH'(1);
               state_d = last_q ? S_DONE : S_ACCEPT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign word_ready = (state_q == S_ACCEPT);
   assign wr_en      = (state_q == S_WRITE);
   assign busy       = (state_q == S_ACCEPT) || (state_q == S_WRITE);
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERROR);
   assign wr_addr    = addr_q;
   assign word_count = count_q;
   assign wr_data    = wr_en ? DATA_WIDTH'(word_q >> lane_lsb(idx_q, DATA_WIDTH)) : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; dut 0 uses a 4 KiB target, dut 1 an 8-byte target.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_v        [2];
   logic        start_v      [2];
   logic [31:0] word_in_v    [2];
   logic        word_valid_v [2];
   logic        word_last_v  [2];
   logic        word_ready_v [2];
   logic        wr_en_v      [2];
   logic [31:0] wr_addr_v    [2];
   logic [7:0]  wr_data_v    [2];
   logic        busy_v       [2];
   logic        done_v       [2];
   logic        error_v      [2];
   logic [31:0] word_count_v [2];

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int bad_accept_wr = 0;

   logic [31:0] log_addr[$];
   logic [7:0]  log_data[$];
   logic [31:0] log1_addr[$];
   logic [7:0]  mem0 [4096];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   imem_loader dut0 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .word_in(word_in_v[0]),
      .word_valid(word_valid_v[0]), .word_last(word_last_v[0]), .word_ready(word_ready_v[0]),
      .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]), .busy(busy_v[0]),
      .done(done_v[0]), .error(error_v[0]), .word_count(word_count_v[0])
   );

   imem_loader #(.MEM_BYTES(8)) dut1 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .word_in(word_in_v[1]),
      .word_valid(word_valid_v[1]), .word_last(word_last_v[1]), .word_ready(word_ready_v[1]),
      .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]), .busy(busy_v[1]),
      .done(done_v[1]), .error(error_v[1]), .word_count(word_count_v[1])
   );

   // Write monitor: acts as the instruction memory byte array.
   always @(negedge clk) begin
      if (wr_en_v[0]) begin
         log_addr.push_back(wr_addr_v[0]);
         log_data.push_back(wr_data_v[0]);
         if (wr_addr_v[0] < 4096) mem0[wr_addr_v[0][11:0]] = wr_data_v[0];
         if (word_ready_v[0]) bad_accept_wr++;
      end
      if (wr_en_v[1]) log1_addr.push_back(wr_addr_v[1]);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr_log();
      log_addr.delete();
      log_data.delete();
      log1_addr.delete();
      for (int i = 0; i < 4096; i++) mem0[i] = 8'h00;
   endtask

   task automatic pulse_start(input int sel);
      start_v[sel] = 1'b1;
      step();
      start_v[sel] = 1'b0;
   endtask

   // Present one word; returns the cycle number of the handshake edge.
   task automatic send(input int sel, input logic [31:0] w, input logic last, input int gap,
                       output int hs_cyc);
      int t;
      word_valid_v[sel] = 1'b0;
      step(gap);
      word_in_v[sel]    = w;
      word_last_v[sel]  = last;
      word_valid_v[sel] = 1'b1;
      t = 0;
      while (!word_ready_v[sel] && t < 60) begin
         step();
         t++;
      end
      chk("hs_ready", 32'(word_ready_v[sel]), 32'd1);
      hs_cyc = cyc;
      step();
      word_valid_v[sel] = 1'b0;
   endtask

   task automatic wait_done(input int sel);
      int t = 0;
      while (!done_v[sel] && t < 60) begin
         step();
         t++;
      end
      chk("done_wait", 32'(done_v[sel]), 32'd1);
   endtask

   // Reference: word j occupies bytes 4j..4j+3, least significant byte first.
   task automatic check_session(input logic [31:0] ws[$], input string tag);
      int nb;
      logic [31:0] rb;
      nb = ws.size() * 4;
      chk({tag, "_nwr"}, 32'(log_addr.size()), 32'(nb));
      for (int i = 0; i < nb && i < log_addr.size(); i++) begin
         chk({tag, "_addr"}, log_addr[i], 32'(i));
         chk({tag, "_data"}, 32'(log_data[i]), (ws[i / 4] >> (8 * (i % 4))) & 32'hff);
      end
      for (int j = 0; j < ws.size(); j++) begin
         rb = {mem0[4*j+3], mem0[4*j+2], mem0[4*j+1], mem0[4*j]};
         chk({tag, "_readback"}, rb, ws[j]);
      end
   endtask

   initial begin
      logic [31:0] ws[$];
      int hs[$];
      int h;
      int nw;
      logic [31:0] w;

      for (int k = 0; k < 2; k++) begin
         rst_v[k] = 1'b1; start_v[k] = 1'b0; word_in_v[k] = '0;
         word_valid_v[k] = 1'b0; word_last_v[k] = 1'b0;
      end
      clr_log();
      step(3);
      chk("rst_ready", 32'(word_ready_v[0]), 0);
      chk("rst_wr_en", 32'(wr_en_v[0]), 0);
      chk("rst_wr_addr", wr_addr_v[0], 0);
      chk("rst_wr_data", 32'(wr_data_v[0]), 0);
      chk("rst_busy", 32'(busy_v[0]), 0);
      chk("rst_done", 32'(done_v[0]), 0);
      chk("rst_error", 32'(error_v[0]), 0);
      chk("rst_count", word_count_v[0], 0);
      // Simultaneous rst and start: reset must win.
      start_v[0] = 1'b1;
      step();
      start_v[0] = 1'b0;
      chk("rst_vs_start_busy", 32'(busy_v[0]), 0);
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;

      // word_valid in IDLE is ignored
      word_in_v[0] = 32'hdeadbeef; word_valid_v[0] = 1'b1; word_last_v[0] = 1'b1;
      step(8);
      chk("idle_ready", 32'(word_ready_v[0]), 0);
      chk("idle_nwr", 32'(log_addr.size()), 0);
      word_valid_v[0] = 1'b0;

      // Single word, byte-by-byte
      clr_log();
      pulse_start(0);
      chk("start_busy", 32'(busy_v[0]), 1);
      send(0, 32'h00500093, 1'b1, 0, h);
      for (int i = 0; i < 4; i++) begin
         chk("single_wr_en", 32'(wr_en_v[0]), 1);
         chk("single_addr", wr_addr_v[0], 32'(i));
         chk("single_data", 32'(wr_data_v[0]), (32'h00500093 >> (8 * i)) & 32'hff);
         step();
      end
      chk("single_done", 32'(done_v[0]), 1);
      chk("single_count", word_count_v[0], 1);
      chk("single_busy", 32'(busy_v[0]), 0);

      // Three back-to-back words; restart from DONE
      clr_log();
      pulse_start(0);
      chk("restart_done_clr", 32'(done_v[0]), 0);
      chk("restart_count_clr", word_count_v[0], 0);
      chk("restart_addr", wr_addr_v[0], 0);
      ws = '{32'h00100093, 32'h00208113, 32'hfe010113};
      hs.delete();
      for (int j = 0; j < 3; j++) begin
         send(0, ws[j], j == 2, 0, h);
         hs.push_back(h);
      end
      wait_done(0);
      chk("b2b_period1", 32'(hs[1] - hs[0]), 5);
      chk("b2b_period2", 32'(hs[2] - hs[1]), 5);
      chk("b2b_count", word_count_v[0], 3);
      check_session(ws, "b2b");

      // Randomized sessions with valid gaps; one start pulse injected while busy
      for (int s = 0; s < 4; s++) begin
         clr_log();
         ws.delete();
         pulse_start(0);
         nw = $urandom_range(6, 1);
         for (int j = 0; j < nw; j++) begin
            w = $urandom;
            ws.push_back(w);
            send(0, w, j == nw - 1, $urandom_range(7, 0), h);
            if (j == 0 && nw > 1) pulse_start(0);
         end
         wait_done(0);
         chk("rand_count", word_count_v[0], 32'(nw));
         check_session(ws, "rand");
      end
      chk("no_write_in_accept", 32'(bad_accept_wr), 0);

      // Reset in the middle of a word's byte writes
      clr_log();
      pulse_start(0);
      send(0, 32'h11223344, 1'b0, 0, h);
      send(0, 32'h55667788, 1'b0, 0, h);
      chk("midrst_count_before", word_count_v[0], 1);
      step();
      chk("midrst_byte1_addr", wr_addr_v[0], 5);
      rst_v[0] = 1'b1;
      step();
      rst_v[0] = 1'b0;
      chk("midrst_wr_en", 32'(wr_en_v[0]), 0);
      chk("midrst_busy", 32'(busy_v[0]), 0);
      chk("midrst_count", word_count_v[0], 0);
      chk("midrst_addr", wr_addr_v[0], 0);
      clr_log();
      pulse_start(0);
      ws = '{32'hcafef00d};
      send(0, ws[0], 1'b1, 2, h);
      wait_done(0);
      check_session(ws, "reload");

      // Overflow on an 8-byte target
      pulse_start(1);
      send(1, 32'ha1a2a3a4, 1'b0, 0, h);
      send(1, 32'hb1b2b3b4, 1'b0, 1, h);
      send(1, 32'hc1c2c3c4, 1'b1, 0, h);
      chk("ovf_error", 32'(error_v[1]), 1);
      chk("ovf_done", 32'(done_v[1]), 0);
      chk("ovf_count", word_count_v[1], 2);
      chk("ovf_wr_en", 32'(wr_en_v[1]), 0);
      step(6);
      chk("ovf_error_held", 32'(error_v[1]), 1);
      chk("ovf_nwr", 32'(log1_addr.size()), 8);
      for (int i = 0; i < 8 && i < log1_addr.size(); i++) chk("ovf_addr", log1_addr[i], 32'(i));
      pulse_start(1);
      chk("ovf_restart_error", 32'(error_v[1]), 0);
      chk("ovf_restart_ready", 32'(word_ready_v[1]), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
